// File: rtl/misao_mem_responder_if.sv
// Byte memory port and boot stream bundle between the MISA-O core side and the responder.
interface misao_mem_responder_if;
  logic [14:0] mem_addr;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic        mem_rw;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        boot_valid;
  logic [7:0]  boot_data;
  logic        boot_ready;
  logic        core_rst;
  logic        boot_done;
  logic        boot_err;

  // Core and boot source side.
  modport master (
    output mem_addr, mem_enable_read, mem_enable_write, mem_rw, mem_data_out,
    output boot_valid, boot_data,
    input  mem_data_in, boot_ready, core_rst, boot_done, boot_err
  );

  // Responder side.
  modport slave (
    input  mem_addr, mem_enable_read, mem_enable_write, mem_rw, mem_data_out,
    input  boot_valid, boot_data,
    output mem_data_in, boot_ready, core_rst, boot_done, boot_err
  );
endinterface

// File: rtl/misao_mem_responder.sv
// Byte-array memory responder for MISA-O with a length-prefixed boot loader that holds the
// core in reset until the image has been written from address 0.
module misao_mem_responder #(
  parameter int unsigned DEPTH_W = 10
) (
  input logic                  clk,
  input logic                  rst,
  misao_mem_responder_if.slave bus_io
);

  localparam int unsigned Size = 32'd1 << DEPTH_W;

  localparam logic [2:0] StLenLo = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [DEPTH_W-1:0] wptr_q, wptr_d;
  logic               core_rst_q, boot_done_q, boot_err_q;
  logic [7:0]         mem_q [Size];

  logic        boot_ready;
  logic        accept;
  logic        addr_in_range;
  logic        load_wr;
  logic        core_wr;
  logic [15:0] len_full;

  assign boot_ready    = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StLoad);
  assign accept        = bus_io.boot_valid && boot_ready;
  assign addr_in_range = 32'(bus_io.mem_addr) < Size;
  assign len_full      = {bus_io.boot_data, len_q[7:0]};
  assign load_wr       = accept && (state_q == StLoad);
  // Core writes are only honoured once the core has been released.
  assign core_wr       = (state_q == StRun) && bus_io.mem_enable_write && !bus_io.mem_rw &&
                         addr_in_range;

  // Loader next-state: consume one boot byte per accepted handshake.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    wptr_d      = wptr_q;
    if (accept) begin
      case (state_q)
        StLenLo: begin
          len_d   = {len_q[15:8], bus_io.boot_data};
          state_d = StLenHi;
        end
        StLenHi: begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StRun;
          end else if (32'(len_full) > Size) begin
            state_d = StErr;
          end else begin
            wptr_d      = '0;
            remaining_d = len_full;
            state_d     = StLoad;
          end
        end
        StLoad: begin
          wptr_d      = wptr_q + 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StRun;
        end
        default: ;
      endcase
    end
  end

  // Loader state and registered core-control outputs; decoded from state_d so they change
  // on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLenLo;
      len_q       <= '0;
      remaining_q <= '0;
      wptr_q      <= '0;
      core_rst_q  <= 1'b1;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      wptr_q      <= wptr_d;
      core_rst_q  <= (state_d != StRun);
      boot_done_q <= (state_d == StRun);
      boot_err_q  <= (state_d == StErr);
    end
  end

  // Array writes; contents survive rst. Loader and core writes never overlap (LOAD vs RUN).
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem_q[wptr_q] <= bus_io.boot_data;
    end else if (core_wr) begin
      mem_q[bus_io.mem_addr[DEPTH_W-1:0]] <= bus_io.mem_data_out;
    end
  end

  assign bus_io.mem_data_in = (bus_io.mem_enable_read && addr_in_range) ?
                              mem_q[bus_io.mem_addr[DEPTH_W-1:0]] : 8'h00;
  assign bus_io.boot_ready  = boot_ready;
  assign bus_io.core_rst    = core_rst_q;
  assign bus_io.boot_done   = boot_done_q;
  assign bus_io.boot_err    = boot_err_q;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Bench for misao_mem_responder: directed boot/core traffic with a byte-count based model
// checked every cycle, plus literal expectations from the test plan.
module tb_misao_mem_responder;

  localparam int unsigned DepthW = 10;
  localparam int unsigned Size   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  misao_mem_responder_if bus ();

  misao_mem_responder #(.DEPTH_W(DepthW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: everything follows from how many boot bytes were accepted since reset.
  int unsigned m_n   = 0;
  int unsigned m_len = 0;
  logic [7:0]  m_b0  = 8'h00;
  logic [7:0]  m_mem [Size];
  bit          m_known [Size];
  bit          m_acc;
  bit          m_wr;

  function automatic bit m_ready();
    return (m_n < 2) || (m_len != 0 && m_len <= Size && m_n < m_len + 2);
  endfunction

  function automatic bit m_done();
    return (m_n >= 2) && (m_len <= Size) && (m_n == m_len + 2);
  endfunction

  function automatic bit m_err();
    return (m_n >= 2) && (m_len > Size);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model update at each edge using pre-edge model state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n   = 0;
      m_len = 0;
    end else begin
      m_acc = bus.boot_valid && m_ready();
      m_wr  = m_done() && bus.mem_enable_write && !bus.mem_rw && (bus.mem_addr < 15'(Size));
      if (m_wr) begin
        m_mem[bus.mem_addr[9:0]]   = bus.mem_data_out;
        m_known[bus.mem_addr[9:0]] = 1'b1;
      end
      if (m_acc) begin
        if (m_n == 0) m_b0 = bus.boot_data;
        else if (m_n == 1) m_len = {16'd0, bus.boot_data, m_b0};
        else begin
          m_mem[m_n - 2]   = bus.boot_data;
          m_known[m_n - 2] = 1'b1;
        end
        m_n++;
      end
    end
  end

  // Per-cycle compare just before the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      #4;
      check("boot_ready", {7'd0, bus.boot_ready}, {7'd0, m_ready()});
      check("core_rst", {7'd0, bus.core_rst}, {7'd0, !m_done()});
      check("boot_done", {7'd0, bus.boot_done}, {7'd0, m_done()});
      check("boot_err", {7'd0, bus.boot_err}, {7'd0, m_err()});
      if (!bus.mem_enable_read || bus.mem_addr >= 15'(Size)) begin
        check("rd_zero", bus.mem_data_in, 8'h00);
      end else if (m_known[bus.mem_addr[9:0]]) begin
        check("rd_data", bus.mem_data_in, m_mem[bus.mem_addr[9:0]]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.boot_valid = 1'b1;
    bus.boot_data  = b;
    @(negedge clk);
    bus.boot_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd(input logic [14:0] addr, input logic [7:0] exp, input string name);
    bus.mem_enable_read = 1'b1;
    bus.mem_rw          = 1'b1;
    bus.mem_addr        = addr;
    #1 check(name, bus.mem_data_in, exp);
    @(negedge clk);
  endtask

  // Core write with read of the same address enabled in the same cycle.
  task automatic wr(input logic [14:0] addr, input logic [7:0] data);
    bus.mem_enable_write = 1'b1;
    bus.mem_enable_read  = 1'b1;
    bus.mem_rw           = 1'b0;
    bus.mem_addr         = addr;
    bus.mem_data_out     = data;
    @(negedge clk);
    bus.mem_enable_write = 1'b0;
    bus.mem_rw           = 1'b1;
  endtask

  logic [7:0] img [5];

  initial begin
    bus.mem_addr         = '0;
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
    bus.mem_rw           = 1'b1;
    bus.mem_data_out     = 8'h00;
    bus.boot_valid       = 1'b0;
    bus.boot_data        = 8'h00;
    img[0] = 8'h03; img[1] = 8'h00; img[2] = 8'hA4; img[3] = 8'h5B; img[4] = 8'hC6;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_core_rst", {7'd0, bus.core_rst}, 8'h01);
    check("rst_boot_ready", {7'd0, bus.boot_ready}, 8'h01);
    check("rst_boot_done", {7'd0, bus.boot_done}, 8'h00);
    check("rst_boot_err", {7'd0, bus.boot_err}, 8'h00);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Nominal load, back-to-back.
    for (int i = 0; i < 5; i++) send(img[i]);
    check("nom_core_rst", {7'd0, bus.core_rst}, 8'h00);
    check("nom_done", {7'd0, bus.boot_done}, 8'h01);
    rd(15'h0000, 8'hA4, "nom_rd0");
    rd(15'h0001, 8'h5B, "nom_rd1");
    rd(15'h0002, 8'hC6, "nom_rd2");

    // Backpressure: valid low on alternate cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(img[i]);
      if (i < 4) begin
        check("bp_not_done", {7'd0, bus.boot_done}, 8'h00);
        @(negedge clk);
      end
    end
    check("bp_done", {7'd0, bus.boot_done}, 8'h01);
    rd(15'h0000, 8'hA4, "bp_rd0");
    rd(15'h0002, 8'hC6, "bp_rd2");

    // Zero length, then core writes.
    do_reset();
    send(8'h00);
    check("z_core_rst_1", {7'd0, bus.core_rst}, 8'h01);
    send(8'h00);
    check("z_core_rst_0", {7'd0, bus.core_rst}, 8'h00);
    wr(15'h0005, 8'h3C);
    rd(15'h0005, 8'h3C, "z_rd5");
    wr(15'h0400, 8'h99);
    rd(15'h0000, 8'hA4, "oor_wr_alias");

    // Oversize length: 0x0401 > 1024.
    do_reset();
    send(8'h01);
    send(8'h04);
    check("ovr_err", {7'd0, bus.boot_err}, 8'h01);
    check("ovr_ready", {7'd0, bus.boot_ready}, 8'h00);
    check("ovr_core_rst", {7'd0, bus.core_rst}, 8'h01);
    send(8'hAB);
    send(8'hCD);
    check("ovr_err_hold", {7'd0, bus.boot_err}, 8'h01);
    rd(15'h0000, 8'hA4, "ovr_rd0");

    // Write gating during LOAD, out-of-range and disabled reads.
    do_reset();
    send(8'h02);
    send(8'h00);
    send(8'h11);
    wr(15'h0000, 8'h77);
    send(8'h22);
    rd(15'h0000, 8'h11, "gate_rd0");
    rd(15'h0001, 8'h22, "gate_rd1");
    rd(15'h7FFF, 8'h00, "rd_oor");
    bus.mem_enable_read = 1'b0;
    bus.mem_addr        = 15'h0000;
    #1 check("rd_disabled", bus.mem_data_in, 8'h00);
    @(negedge clk);

    // Reset mid-load after 2 of 4 data bytes.
    do_reset();
    send(8'h04);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    rst = 1'b1;
    #1;
    check("mid_core_rst", {7'd0, bus.core_rst}, 8'h01);
    check("mid_ready", {7'd0, bus.boot_ready}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    send(8'h01);
    send(8'h00);
    send(8'hE1);
    check("mid_done", {7'd0, bus.boot_done}, 8'h01);
    rd(15'h0000, 8'hE1, "mid_rd0");
    rd(15'h0001, 8'hBB, "mid_rd1");

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
